rgb565_byte_serializer: RTL and testbench

Converts a stream of RGB565 framebuffer pixels back into the RGB888 byte stream used on the SD card side. Each pixel is expanded to three bytes in R, G, B order, and the stream is padded out to a whole sector at end of frame. It sits between the framebuffer read port and the SD write path, and is used for screenshot and frame dump. Both sides use valid/ready handshakes so the SD writer can stall the stream at any byte.

---
 rtl/rgb565_byte_serializer_pkg.sv | 36 +++
 rtl/rgb565_byte_serializer_byte_sector_counter.sv | 40 ++++
 rtl/rgb565_byte_serializer.sv | 110 +++++++++++
 tb/tb_rgb565_byte_serializer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb565_byte_serializer_pkg.sv
// Shared image-format definitions: serializer states, RGB565 field positions
// and the RGB565 -> RGB888 bit-replication expansion.
package rgb565_byte_serializer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEND_R,
      SEND_G,
      SEND_B,
      PAD
   } state_e;

   // RGB565 layout {r[4:0], g[5:0], b[4:0]}; also used by the RGB888-to-RGB565 formatter
   localparam int R_MSB = 15;
   localparam int R_LSB = 11;
   localparam int G_MSB = 10;
   localparam int G_LSB = 5;
   localparam int B_MSB = 4;
   localparam int B_LSB = 0;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;

   // Replicating the field MSBs into the low bits maps full-scale to 8'hFF
   function automatic rgb888_t rgb565_to_rgb888(input logic [15:0] px);
      rgb888_t o;
      o.r = {px[R_MSB:R_LSB], px[R_MSB:R_MSB-2]};
      o.g = {px[G_MSB:G_LSB], px[G_MSB:G_MSB-1]};
      o.b = {px[B_MSB:B_LSB], px[B_MSB:B_MSB-2]};
      return o;
   endfunction

endpackage

// File: rtl/rgb565_byte_serializer_byte_sector_counter.sv
// Wrapping byte-in-sector counter; flags the byte that completes a sector and
// pulses sector_done the cycle after it transfers.
module byte_sector_counter
   import rgb565_byte_serializer_pkg::*;
#(
   parameter int SECTOR_BYTES = 512
) (
   input  logic clk,
   input  logic reset_n,
   input  logic inc,
   output logic wrap_next,
   output logic sector_done
);

   localparam int            CW   = (SECTOR_BYTES > 1) ? $clog2(SECTOR_BYTES) : 1;
   localparam logic [CW-1:0] LAST = CW'(SECTOR_BYTES - 1);

   logic [CW-1:0] cnt_d, cnt_q;
   logic          sector_done_d, sector_done_q;

   assign wrap_next   = (cnt_q == LAST);
   assign sector_done = sector_done_q;

   always_comb begin
      cnt_d         = cnt_q;
      sector_done_d = inc & wrap_next;
      if (inc) cnt_d = wrap_next ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q         <= '0;
         sector_done_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         sector_done_q <= sector_done_d;
      end
   end

endmodule

// File: rtl/rgb565_byte_serializer.sv
// Expands RGB565 pixels into an R,G,B byte stream and pads the final sector of
// each frame with PAD_BYTE so frames always end on a sector boundary.
module rgb565_byte_serializer
   import rgb565_byte_serializer_pkg::*;
#(
   parameter int         SECTOR_BYTES = 512,
   parameter logic [7:0] PAD_BYTE     = 8'h00
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] pixel_data,
   input  logic        pixel_valid,
   input  logic        pixel_last,
   output logic        pixel_ready,
   output logic [7:0]  byte_data,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic        sector_done,
   output logic        frame_done
);

   state_e     state_d, state_q;
   rgb888_t    hold_d, hold_q;
   logic       last_d, last_q;
   logic [7:0] byte_data_d, byte_data_q;
   logic       byte_valid_d, byte_valid_q;
   logic       frame_done_d, frame_done_q;
   logic       pix_acc, byte_acc, wrap_next;

   // A new pixel may be taken while the previous pixel's B byte leaves
   assign pixel_ready = reset_n & ((state_q == IDLE) |
                        ((state_q == SEND_B) & byte_ready & ~last_q));
   assign pix_acc     = pixel_valid & pixel_ready;
   assign byte_acc    = byte_valid_q & byte_ready;

   assign byte_data   = byte_data_q;
   assign byte_valid  = byte_valid_q;
   assign frame_done  = frame_done_q;

   byte_sector_counter #(.SECTOR_BYTES(SECTOR_BYTES)) u_cnt (
      .clk         (clk),
      .reset_n     (reset_n),
      .inc         (byte_acc),
      .wrap_next   (wrap_next),
      .sector_done (sector_done)
   );

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      last_d       = last_q;
      frame_done_d = 1'b0;
      if (pix_acc) begin
         hold_d = rgb565_to_rgb888(pixel_data);
         last_d = pixel_last;
      end
      case (state_q)
         IDLE:   if (pix_acc) state_d = SEND_R;
         SEND_R: if (byte_acc) state_d = SEND_G;
         SEND_G: if (byte_acc) state_d = SEND_B;
         SEND_B: if (byte_acc) begin
            if (last_q) begin
               // Frame already sector-aligned: skip padding entirely
               if (wrap_next) begin
                  state_d      = IDLE;
                  frame_done_d = 1'b1;
               end else begin
                  state_d = PAD;
               end
            end else begin
               state_d = pix_acc ? SEND_R : IDLE;
            end
         end
         PAD:    if (byte_acc && wrap_next) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so they are derived from the next state
      byte_valid_d = (state_d != IDLE);
      case (state_d)
         SEND_R:  byte_data_d = hold_d.r;
         SEND_G:  byte_data_d = hold_d.g;
         SEND_B:  byte_data_d = hold_d.b;
         PAD:     byte_data_d = PAD_BYTE;
         default: byte_data_d = byte_data_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         hold_q       <= '0;
         last_q       <= 1'b0;
         byte_data_q  <= 8'h00;
         byte_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         last_q       <= last_d;
         byte_data_q  <= byte_data_d;
         byte_valid_q <= byte_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_rgb565_byte_serializer.sv
// Directed bench for rgb565_byte_serializer: three instances (16/6/4-byte
// sectors) share stimulus; sel picks which one is observed.
module tb_rgb565_byte_serializer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] pixel_data = 16'h0;
   logic        pixel_valid = 1'b0;
   logic        pixel_last = 1'b0;
   logic        byte_ready = 1'b0;

   logic        pr_a [3];
   logic        bv_a [3];
   logic        sd_a [3];
   logic        fd_a [3];
   logic [7:0]  bd_a [3];
   int          sel = 0;

   logic        pixel_ready, byte_valid, sector_done, frame_done;
   logic [7:0]  byte_data;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   logic [15:0] pix_d [$];
   bit          pix_l [$];
   logic [7:0]  got [$];
   logic [7:0]  exp_b [$];
   int          sd_at [$];
   int          fd_at [$];
   int          both_cnt, hold_err, pad_rdy, acc_cyc, first_bv, fd_cyc;

   always #5 clk = ~clk;

   rgb565_byte_serializer #(.SECTOR_BYTES(16)) u_s16 (
      .clk(clk), .reset_n(reset_n), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
      .pixel_last(pixel_last), .pixel_ready(pr_a[0]), .byte_data(bd_a[0]), .byte_valid(bv_a[0]),
      .byte_ready(byte_ready), .sector_done(sd_a[0]), .frame_done(fd_a[0]));
   rgb565_byte_serializer #(.SECTOR_BYTES(6)) u_s6 (
      .clk(clk), .reset_n(reset_n), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
      .pixel_last(pixel_last), .pixel_ready(pr_a[1]), .byte_data(bd_a[1]), .byte_valid(bv_a[1]),
      .byte_ready(byte_ready), .sector_done(sd_a[1]), .frame_done(fd_a[1]));
   rgb565_byte_serializer #(.SECTOR_BYTES(4)) u_s4 (
      .clk(clk), .reset_n(reset_n), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
      .pixel_last(pixel_last), .pixel_ready(pr_a[2]), .byte_data(bd_a[2]), .byte_valid(bv_a[2]),
      .byte_ready(byte_ready), .sector_done(sd_a[2]), .frame_done(fd_a[2]));

   always_comb begin
      pixel_ready = pr_a[sel];
      byte_valid  = bv_a[sel];
      byte_data   = bd_a[sel];
      sector_done = sd_a[sel];
      frame_done  = fd_a[sel];
   end

   // Reference expansion written arithmetically
   function automatic logic [23:0] exp565(input logic [15:0] p);
      logic [7:0] r, g, b;
      r = {3'b0, p[15:11]};
      g = {2'b0, p[10:5]};
      b = {3'b0, p[4:0]};
      return {(r << 3) | (r >> 2), (g << 2) | (g >> 4), (b << 3) | (b >> 2)};
   endfunction

   function automatic void push_exp(input logic [15:0] p);
      logic [23:0] e;
      e = exp565(p);
      exp_b.push_back(e[23:16]);
      exp_b.push_back(e[15:8]);
      exp_b.push_back(e[7:0]);
   endfunction

   function automatic int first_diff();
      int n;
      n = (got.size() < exp_b.size()) ? got.size() : exp_b.size();
      for (int i = 0; i < n; i++) if (got[i] !== exp_b[i]) return i;
      return (got.size() == exp_b.size()) ? -1 : n;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0; pixel_valid = 1'b0; pixel_last = 1'b0; byte_ready = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Drives pix_d/pix_l, collects bytes and pulse positions; no checking here
   task automatic run(input bit rnd, input int budget, output bit timeout);
      int pi = 0, stall = 0;
      bit last_sent = 0, prev_stall = 0, done = 0;
      logic [7:0] prev_d = 8'h0;
      got.delete(); sd_at.delete(); fd_at.delete();
      both_cnt = 0; hold_err = 0; pad_rdy = 0; acc_cyc = -1; first_bv = -1; fd_cyc = -1;
      timeout = 1'b1;
      for (int cyc = 0; cyc < budget && !done; cyc++) begin
         @(negedge clk);
         pixel_valid = (pi < pix_d.size());
         pixel_data  = pixel_valid ? pix_d[pi] : 16'h0;
         pixel_last  = pixel_valid ? pix_l[pi] : 1'b0;
         if (!rnd) byte_ready = 1'b1;
         else if (stall > 0) begin byte_ready = 1'b0; stall--; end
         else if ($urandom_range(0, 15) == 0) begin byte_ready = 1'b0; stall = 4; end
         else byte_ready = ($urandom_range(0, 2) != 0);
         #1;
         if (sector_done) sd_at.push_back(got.size());
         if (frame_done) begin fd_at.push_back(got.size()); fd_cyc = cyc; end
         if (sector_done && frame_done) both_cnt++;
         if (prev_stall && (!byte_valid || byte_data !== prev_d)) hold_err++;
         if (last_sent && pixel_ready && byte_valid) pad_rdy++;
         if (byte_valid && first_bv < 0) first_bv = cyc;
         if (byte_valid && byte_ready) got.push_back(byte_data);
         if (pixel_valid && pixel_ready) begin
            if (acc_cyc < 0) acc_cyc = cyc;
            if (pix_l[pi]) last_sent = 1'b1;
            pi++;
         end
         prev_stall = byte_valid && !byte_ready;
         prev_d     = byte_data;
         if (fd_at.size() > 0 ||
             (pi == pix_d.size() && !last_sent && !byte_valid && got.size() > 0)) begin
            done = 1'b1; timeout = 1'b0;
         end
      end
      pixel_valid = 1'b0; pixel_last = 1'b0; byte_ready = 1'b1;
   endtask

   task automatic test_reset();
      sel = 0;
      @(negedge clk);
      reset_n = 1'b0; byte_ready = 1'b1; pixel_valid = 1'b1;
      #1;
      tot_cnt++; if (pixel_ready !== 1'b0) $display("FAIL rst_pixel_ready got=%b exp=0", pixel_ready); else pass_cnt++;
      tot_cnt++; if (byte_valid !== 1'b0 || byte_data !== 8'h00)
         $display("FAIL rst_byte got valid=%b data=%h exp valid=0 data=00", byte_valid, byte_data); else pass_cnt++;
      tot_cnt++; if (sector_done !== 1'b0 || frame_done !== 1'b0)
         $display("FAIL rst_pulses got sd=%b fd=%b exp 0 0", sector_done, frame_done); else pass_cnt++;
      pixel_valid = 1'b0;
      @(negedge clk); reset_n = 1'b1; #1;
      tot_cnt++; if (pixel_ready !== 1'b1) $display("FAIL idle_pixel_ready got=%b exp=1", pixel_ready); else pass_cnt++;
   endtask

   task automatic test_colour();
      logic [15:0] px [4];
      logic [23:0] ex [4];
      bit to;
      px = '{16'hF800, 16'h07E0, 16'h001F, 16'h8410};
      ex = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h848284};
      sel = 0;
      for (int i = 0; i < 4; i++) begin
         do_reset();
         pix_d = '{px[i]}; pix_l = '{1'b0};
         run(1'b0, 40, to);
         tot_cnt++;
         if (to || got.size() != 3 || {got[0], got[1], got[2]} !== ex[i])
            $display("FAIL colour_%h got n=%0d bytes=%h timeout=%b exp=%h", px[i], got.size(),
                     (got.size() == 3) ? {got[0], got[1], got[2]} : 24'hx, to, ex[i]);
         else pass_cnt++;
         if (i == 0) begin
            tot_cnt++; if (first_bv - acc_cyc != 1)
               $display("FAIL latency got=%0d exp=1", first_bv - acc_cyc); else pass_cnt++;
         end
      end
   endtask

   task automatic test_padding();
      bit to; int d;
      sel = 0; do_reset();
      pix_d = '{16'hFFFF, 16'hFFFF}; pix_l = '{1'b0, 1'b1};
      exp_b.delete();
      repeat (6) exp_b.push_back(8'hFF);
      repeat (10) exp_b.push_back(8'h00);
      run(1'b0, 100, to);
      d = first_diff();
      tot_cnt++; if (to || d >= 0) $display("FAIL pad_bytes diff_at=%0d got_n=%0d exp_n=16 timeout=%b", d, got.size(), to); else pass_cnt++;
      tot_cnt++; if (sd_at.size() != 1 || sd_at[0] != 16)
         $display("FAIL pad_sector_done got n=%0d first=%0d exp one at 16", sd_at.size(), (sd_at.size() > 0) ? sd_at[0] : -1); else pass_cnt++;
      tot_cnt++; if (fd_at.size() != 1 || fd_at[0] != 16)
         $display("FAIL pad_frame_done got n=%0d exp one at 16", fd_at.size()); else pass_cnt++;
      tot_cnt++; if (both_cnt != 1) $display("FAIL pad_coincide got=%0d exp=1", both_cnt); else pass_cnt++;
      tot_cnt++; if (pad_rdy != 0) $display("FAIL pad_pixel_ready got=%0d cycles exp=0", pad_rdy); else pass_cnt++;
      tot_cnt++; if (fd_cyc - first_bv != 16) $display("FAIL throughput got=%0d cycles exp=16", fd_cyc - first_bv); else pass_cnt++;
   endtask

   task automatic test_aligned();
      bit to; int d;
      sel = 1; do_reset();
      pix_d = '{16'hF800, 16'h001F}; pix_l = '{1'b0, 1'b1};
      exp_b = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
      run(1'b0, 100, to);
      d = first_diff();
      tot_cnt++; if (to || d >= 0) $display("FAIL aligned_bytes diff_at=%0d got_n=%0d exp_n=6 timeout=%b", d, got.size(), to); else pass_cnt++;
      tot_cnt++; if (sd_at.size() != 1 || fd_at.size() != 1 || sd_at[0] != 6 || fd_at[0] != 6 || both_cnt != 1)
         $display("FAIL aligned_done got sd_n=%0d fd_n=%0d both=%0d exp one each at 6 together", sd_at.size(), fd_at.size(), both_cnt);
      else pass_cnt++;
   endtask

   task automatic test_straddle();
      bit to; int d;
      sel = 2; do_reset();
      pix_d = '{16'h07E0, 16'h8410, 16'hF800, 16'h001F}; pix_l = '{1'b0, 1'b0, 1'b0, 1'b1};
      exp_b = '{8'h00, 8'hFF, 8'h00, 8'h84, 8'h82, 8'h84, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
      run(1'b0, 100, to);
      d = first_diff();
      tot_cnt++; if (to || d >= 0) $display("FAIL straddle_bytes diff_at=%0d got_n=%0d exp_n=12 timeout=%b", d, got.size(), to); else pass_cnt++;
      tot_cnt++; if (sd_at.size() != 3 || sd_at[0] != 4 || sd_at[1] != 8 || sd_at[2] != 12)
         $display("FAIL straddle_sector_done got n=%0d exp 3 at 4,8,12", sd_at.size()); else pass_cnt++;
      tot_cnt++; if (fd_at.size() != 1 || fd_at[0] != 12 || both_cnt != 1)
         $display("FAIL straddle_frame_done got n=%0d both=%0d exp one at 12 with sector_done", fd_at.size(), both_cnt); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      bit to; int d;
      sel = 0; do_reset();
      pix_d.delete(); pix_l.delete(); exp_b.delete();
      for (int i = 0; i < 100; i++) begin
         pix_d.push_back(16'($urandom()));
         pix_l.push_back(i == 99);
         push_exp(pix_d[i]);
      end
      while (exp_b.size() % 16 != 0) exp_b.push_back(8'h00);
      run(1'b1, 5000, to);
      d = first_diff();
      tot_cnt++; if (to || d >= 0) $display("FAIL bp_bytes diff_at=%0d got_n=%0d exp_n=%0d timeout=%b", d, got.size(), exp_b.size(), to); else pass_cnt++;
      tot_cnt++; if (hold_err != 0) $display("FAIL bp_hold got=%0d unstable cycles exp=0", hold_err); else pass_cnt++;
      tot_cnt++; if (fd_at.size() != 1 || fd_at[0] != 304 || sd_at.size() != 19)
         $display("FAIL bp_done got fd_n=%0d sd_n=%0d exp fd at 304 and 19 sectors", fd_at.size(), sd_at.size()); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      bit to; int d;
      sel = 0; do_reset();
      @(negedge clk);
      pixel_valid = 1'b1; pixel_data = 16'hF800; pixel_last = 1'b0; byte_ready = 1'b1;
      @(negedge clk);
      pixel_valid = 1'b0;
      @(negedge clk); #1;
      tot_cnt++; if (byte_valid !== 1'b1 || byte_data !== 8'h00)
         $display("FAIL mid_in_send_g got valid=%b data=%h exp 1 00", byte_valid, byte_data); else pass_cnt++;
      reset_n = 1'b0; #1;
      tot_cnt++; if (byte_valid !== 1'b0 || byte_data !== 8'h00 || pixel_ready !== 1'b0)
         $display("FAIL mid_reset got valid=%b data=%h prdy=%b exp 0 00 0", byte_valid, byte_data, pixel_ready); else pass_cnt++;
      @(negedge clk); reset_n = 1'b1;
      pix_d = '{16'h001F, 16'h001F}; pix_l = '{1'b0, 1'b1};
      exp_b.delete(); push_exp(16'h001F); push_exp(16'h001F);
      repeat (10) exp_b.push_back(8'h00);
      run(1'b0, 100, to);
      d = first_diff();
      tot_cnt++; if (to || d >= 0 || got[2] !== 8'hFF) $display("FAIL mid_after_bytes diff_at=%0d got_n=%0d exp_n=16 timeout=%b", d, got.size(), to); else pass_cnt++;
      tot_cnt++; if (sd_at.size() != 1 || sd_at[0] != 16)
         $display("FAIL mid_count_restart got first sector_done at %0d exp 16", (sd_at.size() > 0) ? sd_at[0] : -1); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_colour();
      test_padding();
      test_aligned();
      test_straddle();
      test_backpressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
